pipe_scroller: RTL and testbench
================================

PIPE_SCROLLER -- requirements
Module: pipe_scroller

Interface
REQ-001 Parameter SCREEN_W, default 640: visible width in pixels.
REQ-002 Parameter PIP_WIDTH, default 100: pipe width in pixels.
REQ-003 Parameter PASS_X, default 303: bird left edge (bird_HPos 320 - bird_Xwidth/2); the pipe counts as passed when pip_X drops below it.
REQ-004 Parameter GAP_Y_MIN, default 220: lowest gap-top row.
REQ-005 Parameter GAP_Y_MAX, default 460: highest gap-top row.
REQ-006 Parameter LFSR_SEED, default 8'hA5: gap LFSR reset value, non-zero.
REQ-007 clk  in  1  system clock; one clock, all logic on its rising edge.
REQ-008 clrn  in  1  reset, asynchronous, active-low.
REQ-009 tick  in  1  one-cycle scroll-step strobe (divided-clock edge).
REQ-010 state  in  2  game state: 0 ready, 1 play, 2 score; 3 treated as 2.
REQ-011 pip_X  out  10  pipe right-edge column; pipe spans (pip_X-PIP_WIDTH, pip_X).
REQ-012 pip_Y  out  9  gap top row; gap spans (pip_Y-100, pip_Y).
REQ-013 pass  out  1  one-cycle pulse when the bird clears a pipe.
REQ-014 score  out  7  pipes passed, 0..99.

Function
REQ-015 The block SHALL run an FSM with three states: IDLE (state 0), RUN (state 1), FREEZE (state 2/3), selected each cycle from the registered state input.
REQ-016 In IDLE, the block SHALL hold pip_X=SCREEN_W+PIP_WIDTH (740) and pip_Y=240, clear score, hold pass=0, and ignore tick.
REQ-017 In RUN, on a cycle with tick=1, the block SHALL set pip_X <= pip_X - step, with step=1 (see REQ-026).
REQ-018 Wrap: in RUN with tick=1 and pip_X < step, pip_X SHALL load 740 and pip_Y SHALL load the new gap value in the same cycle.
REQ-019 New gap value SHALL be GAP_Y_MIN + lfsr[7:0], clamped to GAP_Y_MAX; arithmetic is 9-bit unsigned with no overflow.
REQ-020 The LFSR SHALL be 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advance every clk cycle in every state, and never reach zero.
REQ-021 pass SHALL be 1 for exactly the cycle after a RUN tick where old pip_X >= PASS_X and new pip_X < PASS_X; a wrap never asserts pass.
REQ-022 Each pass pulse SHALL increment score by 1, saturating at 99.
REQ-023 In FREEZE, pip_X, pip_Y and score SHALL hold, pass=0, and tick is ignored.
REQ-024 Priority: state 0 overrides tick in the same cycle; returning from FREEZE to RUN resumes from the held position.
REQ-025 Outputs SHALL be registered, with 1-cycle latency from tick/state to output.

Reset
REQ-026 With clrn=0, the block SHALL asynchronously force IDLE, pip_X=740, pip_Y=240, score=0, pass=0, lfsr=LFSR_SEED, step=1; deassertion mid-game restarts from IDLE values.

Configuration
REQ-027 Macro PIPE_SPEEDUP_EN defined: step = 1 + score/8, capped at 4; step is recomputed when score changes and is reset to 1 in IDLE. Undefined: step is a constant 1 and no divide logic exists.

Structure
REQ-028 The shared package SHALL hold SCREEN_W, SCREEN_H, PIP_WIDTH, PIP_HEIGHT, LAND_HEIGHT, BIRD_HPOS, BIRD_XWIDTH and the 2-bit game-state encodings; pipe_scroller SHALL import them.
REQ-029 The LFSR SHALL be a sub-module gap_lfsr (clk, clrn, seed parameter, 8-bit out).

Verification
REQ-030 Reset, then state=1 with 437 ticks -> pip_X=303, pass=0; next tick -> pip_X=302, pass pulses once, score=1.
REQ-031 From pip_X=0 in RUN, tick -> pip_X=740, pip_Y within [220,460] and equal to clamp(220+lfsr), pass=0.
REQ-032 state=2 at pip_X=500, 50 ticks -> pip_X=500, score unchanged; state=1, one tick -> 499.
REQ-033 tick and state 1->0 in the same cycle -> pip_X=740, pip_Y=240, score=0.
REQ-034 Run to score 99, then one further pass -> score=99, pass still pulses; with PIPE_SPEEDUP_EN, score 8 -> decrement of 2 per tick.
REQ-035 clrn pulsed low mid-RUN with no clk edge -> outputs at reset values immediately.

Source files
------------

// File: rtl/pipe_scroller_pkg.sv
// pipe_scroller_pkg: shared screen geometry, game-state encodings and scroller state type.
`default_nettype none

package pipe_scroller_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int PIP_WIDTH   = 100;
  localparam int PIP_HEIGHT  = 100;
  localparam int LAND_HEIGHT = 40;
  localparam int BIRD_HPOS   = 320;
  localparam int BIRD_XWIDTH = 34;

  localparam logic [1:0] GS_READY = 2'd0;
  localparam logic [1:0] GS_PLAY  = 2'd1;
  localparam logic [1:0] GS_SCORE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FREEZE = 2'd2
  } scroll_state_t;

  // Scroll speed grows by one pixel per eight pipes passed, up to four.
  function automatic logic [9:0] step_for_score(input logic [6:0] s);
    if (s >= 7'd24) return 10'd4;
    return 10'({7'd0, s[6:3]}) + 10'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_scroller_gap_lfsr.sv
// gap_lfsr: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), free-running, never zero.
`default_nettype none

module gap_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       clrn,
  output logic [7:0] q
);

  logic w_fb;

  assign w_fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  // The all-zero reload is a lockup guard; a maximal sequence from a non-zero seed never hits it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)          q <= SEED;
    else if (q == 8'd0) q <= SEED;
    else                q <= {q[6:0], w_fb};
  end

endmodule

`default_nettype wire

// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolls one pipe leftward, re-spawns it with a random gap, counts passes.
// Optional macro PIPE_SPEEDUP_EN: scroll step grows with score (1 + score/8, max 4).
`default_nettype none

module pipe_scroller
  import pipe_scroller_pkg::*;
#(
  parameter int         SCREEN_W  = pipe_scroller_pkg::SCREEN_W,
  parameter int         PIP_WIDTH = pipe_scroller_pkg::PIP_WIDTH,
  parameter int         PASS_X    = pipe_scroller_pkg::BIRD_HPOS - pipe_scroller_pkg::BIRD_XWIDTH / 2,
  parameter int         GAP_Y_MIN = 220,
  parameter int         GAP_Y_MAX = 460,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       tick,
  input  logic [1:0] state,
  output logic [9:0] pip_X,
  output logic [8:0] pip_Y,
  output logic       pass,
  output logic [6:0] score
);

  localparam logic [9:0] c_x_home = 10'(SCREEN_W + PIP_WIDTH);
  localparam logic [8:0] c_y_home = 9'd240;
  localparam logic [9:0] c_pass_x = 10'(PASS_X);

  logic [7:0]    w_lfsr;
  scroll_state_t w_mode;
  logic [9:0]    w_step;
  logic [9:0]    w_x_dec;
  logic          w_wrap;
  logic          w_pass;
  logic [8:0]    w_gap_sum;
  logic [8:0]    w_gap;
  logic [6:0]    w_score_inc;

  gap_lfsr #(.SEED(LFSR_SEED)) u_gap_lfsr (
    .clk  (clk),
    .clrn (clrn),
    .q    (w_lfsr)
  );

`ifdef PIPE_SPEEDUP_EN
  logic [9:0] r_step;
  assign w_step = r_step;
`else
  assign w_step = 10'd1;
`endif

  always_comb begin
    w_mode = ST_FREEZE;
    case (state)
      GS_READY: w_mode = ST_IDLE;
      GS_PLAY:  w_mode = ST_RUN;
      default:  w_mode = ST_FREEZE;
    endcase
  end

  always_comb begin
    w_wrap      = (pip_X < w_step);
    w_x_dec     = pip_X - w_step;
    w_pass      = !w_wrap && (pip_X >= c_pass_x) && (w_x_dec < c_pass_x);
    w_gap_sum   = 9'(GAP_Y_MIN) + {1'b0, w_lfsr};
    w_gap       = (w_gap_sum > 9'(GAP_Y_MAX)) ? 9'(GAP_Y_MAX) : w_gap_sum;
    w_score_inc = (score >= 7'd99) ? 7'd99 : score + 7'd1;
  end

  // Mode is decoded straight from the state input so a state change lands on the very next edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pip_X <= c_x_home;
      pip_Y <= c_y_home;
      score <= 7'd0;
      pass  <= 1'b0;
`ifdef PIPE_SPEEDUP_EN
      r_step <= 10'd1;
`endif
    end else begin
      pass <= 1'b0;
      case (w_mode)
        ST_IDLE: begin
          pip_X <= c_x_home;
          pip_Y <= c_y_home;
          score <= 7'd0;
`ifdef PIPE_SPEEDUP_EN
          r_step <= 10'd1;
`endif
        end
        ST_RUN: begin
          if (tick) begin
            if (w_wrap) begin
              pip_X <= c_x_home;
              pip_Y <= w_gap;
            end else begin
              pip_X <= w_x_dec;
              if (w_pass) begin
                pass  <= 1'b1;
                score <= w_score_inc;
`ifdef PIPE_SPEEDUP_EN
                r_step <= step_for_score(w_score_inc);
`endif
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller: directed stimulus, per-cycle comparison against a behavioural model.
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_scroller;

  logic       clk = 1'b0;
  logic       clrn;
  logic       tick;
  logic [1:0] state;
  wire  [9:0] pip_X;
  wire  [8:0] pip_Y;
  wire        pass;
  wire  [6:0] score;

  int checks = 0;
  int errors = 0;

  int         m_x     = 740;
  int         m_y     = 240;
  int         m_score = 0;
  int         m_pass  = 0;
  logic [7:0] m_lfsr  = 8'hA5;

  pipe_scroller dut (
    .clk   (clk),
    .clrn  (clrn),
    .tick  (tick),
    .state (state),
    .pip_X (pip_X),
    .pip_Y (pip_Y),
    .pass  (pass),
    .score (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int model_step(input int sc);
`ifdef PIPE_SPEEDUP_EN
    int s;
    s = 1 + sc / 8;
    return (s > 4) ? 4 : s;
`else
    return (sc >= 0) ? 1 : 1;
`endif
  endfunction

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_x = 740; m_y = 240; m_score = 0; m_pass = 0; m_lfsr = 8'hA5;
    end else begin
      int stp;
      stp    = model_step(m_score);
      m_pass = 0;
      if (state == 2'd0) begin
        m_x = 740; m_y = 240; m_score = 0;
      end else if (state == 2'd1 && tick) begin
        if (m_x < stp) begin
          m_x = 740;
          m_y = (220 + int'(m_lfsr) > 460) ? 460 : 220 + int'(m_lfsr);
        end else begin
          if (m_x >= 303 && m_x - stp < 303) begin
            m_pass  = 1;
            m_score = (m_score < 99) ? m_score + 1 : 99;
          end
          m_x = m_x - stp;
        end
      end
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
  end

  always @(negedge clk) begin
    check("pip_X", int'(pip_X), m_x);
    check("pip_Y", int'(pip_Y), m_y);
    check("pass",  int'(pass),  m_pass);
    check("score", int'(score), m_score);
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    tick = 1'b0;
  endtask

  task automatic wait_pass();
    int n;
    n = 0;
    do begin
      ticks(1);
      n++;
    end while (pass !== 1'b1 && n < 800);
    if (pass !== 1'b1) check("pass_timeout", 0, 1);
  endtask

  initial begin
    clrn  = 1'b0;
    tick  = 1'b0;
    state = 2'd0;
    @(negedge clk);
    check("rst_x", int'(pip_X), 740);
    check("rst_y", int'(pip_Y), 240);
    check("rst_score", int'(score), 0);
    check("rst_pass", int'(pass), 0);

    clrn  = 1'b1;
    state = 2'd1;
    ticks(437);
    check("x_after_437", int'(pip_X), 303);
    check("pass_after_437", int'(pass), 0);
    ticks(1);
    check("x_after_438", int'(pip_X), 302);
    check("pass_pulse", int'(pass), 1);
    check("score_first", int'(score), 1);
    ticks(1);
    check("pass_drop", int'(pass), 0);

    ticks(301);
    check("x_zero", int'(pip_X), 0);
    ticks(1);
    check("x_wrap", int'(pip_X), 740);
    check("pass_on_wrap", int'(pass), 0);
    check("gap_in_range", int'(pip_Y >= 9'd220 && pip_Y <= 9'd460), 1);

    ticks(240);
    check("x_500", int'(pip_X), 500);
    state = 2'd2;
    ticks(25);
    state = 2'd3;
    ticks(25);
    check("freeze_x", int'(pip_X), 500);
    check("freeze_score", int'(score), 1);
    state = 2'd1;
    ticks(1);
    check("resume_x", int'(pip_X), 499);

    state = 2'd0;
    ticks(1);
    check("idle_prio_x", int'(pip_X), 740);
    check("idle_prio_y", int'(pip_Y), 240);
    check("idle_prio_score", int'(score), 0);

    state = 2'd1;
    for (int k = 0; k < 99; k++) wait_pass();
    check("score_99", int'(score), 99);
    wait_pass();
    check("sat_pass", int'(pass), 1);
    check("sat_score", int'(score), 99);

    ticks(20);
    #2 clrn = 1'b0;
    #1;
    check("async_x", int'(pip_X), 740);
    check("async_y", int'(pip_Y), 240);
    check("async_score", int'(score), 0);
    check("async_pass", int'(pass), 0);
    @(negedge clk);
    clrn = 1'b1;
    ticks(3);
    check("restart_x", int'(pip_X), 737);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
